// File: rtl/alpha_decode.sv
// Letter code (0=A..25=Z) to 14-segment pattern decoder with a registered output.
// Codes 26-31 and reset drive the blank pattern; ACTIVE_LOW inverts every output bit.
module alpha_decode #(
  parameter int ACTIVE_LOW = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  output logic [0:13] s
);

  localparam logic [0:13] BLANK = (ACTIVE_LOW != 0) ? 14'h3fff : 14'h0000;

  logic [4:0]  w_code;
  logic [0:13] w_pat;
  logic [0:13] w_drv;
  logic [0:13] r_seg;

  assign w_code = {a, b, c, d, e};

  // Unknown inputs never match a letter and fall through to blank, so no stale letter is held.
  always_comb begin
    w_pat = 14'b00000000000000;
    case (w_code)
      5'd0:  w_pat = 14'b11101111000000; // A
      5'd1:  w_pat = 14'b11110001010010; // B
      5'd2:  w_pat = 14'b10011100000000; // C
      5'd3:  w_pat = 14'b11110000010010; // D
      5'd4:  w_pat = 14'b10011110000000; // E
      5'd5:  w_pat = 14'b10001110000000; // F
      5'd6:  w_pat = 14'b10111101000000; // G
      5'd7:  w_pat = 14'b01101111000000; // H
      5'd8:  w_pat = 14'b10010000010010; // I
      5'd9:  w_pat = 14'b01111000000000; // J
      5'd10: w_pat = 14'b00001110001001; // K
      5'd11: w_pat = 14'b00011100000000; // L
      5'd12: w_pat = 14'b01101100101000; // M
      5'd13: w_pat = 14'b01101100100001; // N
      5'd14: w_pat = 14'b11111100000000; // O
      5'd15: w_pat = 14'b11001111000000; // P
      5'd16: w_pat = 14'b11111100000001; // Q
      5'd17: w_pat = 14'b11001111000001; // R
      5'd18: w_pat = 14'b10110111000000; // S
      5'd19: w_pat = 14'b10000000010010; // T
      5'd20: w_pat = 14'b01111100000000; // U
      5'd21: w_pat = 14'b00001100001100; // V
      5'd22: w_pat = 14'b01101100000101; // W
      5'd23: w_pat = 14'b00000000101101; // X
      5'd24: w_pat = 14'b00000000101010; // Y
      5'd25: w_pat = 14'b10010000001100; // Z
      default: w_pat = 14'b00000000000000;
    endcase
  end

  assign w_drv = (ACTIVE_LOW != 0) ? ~w_pat : w_pat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_seg <= BLANK;
    else        r_seg <= w_drv;
  end

  assign s = r_seg;

endmodule

// File: tb/tb_alpha_decode.sv
// Directed bench for alpha_decode: one active-high and one active-low instance
// share the same code inputs and are checked against hand-written patterns.
module tb_alpha_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;
  logic [0:13] s_hi;
  logic [0:13] s_lo;
  int          errors = 0;
  int          checks = 0;

  alpha_decode #(.ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .s(s_hi)
  );
  alpha_decode #(.ACTIVE_LOW(1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .s(s_lo)
  );

  always #5 clk = ~clk;

  function automatic logic [0:13] exp_pat(input int k);
    case (k)
      0:  return 14'b11101111000000;
      1:  return 14'b11110001010010;
      2:  return 14'b10011100000000;
      3:  return 14'b11110000010010;
      4:  return 14'b10011110000000;
      5:  return 14'b10001110000000;
      6:  return 14'b10111101000000;
      7:  return 14'b01101111000000;
      8:  return 14'b10010000010010;
      9:  return 14'b01111000000000;
      10: return 14'b00001110001001;
      11: return 14'b00011100000000;
      12: return 14'b01101100101000;
      13: return 14'b01101100100001;
      14: return 14'b11111100000000;
      15: return 14'b11001111000000;
      16: return 14'b11111100000001;
      17: return 14'b11001111000001;
      18: return 14'b10110111000000;
      19: return 14'b10000000010010;
      20: return 14'b01111100000000;
      21: return 14'b00001100001100;
      22: return 14'b01101100000101;
      23: return 14'b00000000101101;
      24: return 14'b00000000101010;
      25: return 14'b10010000001100;
      default: return 14'b00000000000000;
    endcase
  endfunction

  task automatic set_code(input logic [4:0] code);
    {a, b, c, d, e} = code;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_code(5'd0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_hi !== 14'b00000000000000) begin
      errors++; $display("FAIL reset_hi got=%b exp=%b", s_hi, 14'b00000000000000);
    end
    checks++;
    if (s_lo !== 14'b11111111111111) begin
      errors++; $display("FAIL reset_lo got=%b exp=%b", s_lo, 14'b11111111111111);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_hi !== 14'b11101111000000) begin
      errors++; $display("FAIL first_A_hi got=%b exp=%b", s_hi, 14'b11101111000000);
    end
    checks++;
    if (s_lo !== 14'b00010000111111) begin
      errors++; $display("FAIL first_A_lo got=%b exp=%b", s_lo, 14'b00010000111111);
    end
  endtask

  // Codes change every cycle, so this also covers back-to-back decoding.
  task automatic test_sweep();
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      set_code(5'(k));
      @(posedge clk); #1;
      checks++;
      if (s_hi !== exp_pat(k)) begin
        errors++; $display("FAIL sweep_hi code=%0d got=%b exp=%b", k, s_hi, exp_pat(k));
      end
      checks++;
      if (s_lo !== ~exp_pat(k)) begin
        errors++; $display("FAIL sweep_lo code=%0d got=%b exp=%b", k, s_lo, ~exp_pat(k));
      end
    end
  endtask

  task automatic test_invalid();
    for (int k = 26; k < 32; k++) begin
      @(negedge clk);
      set_code(5'(k));
      @(posedge clk); #1;
      checks++;
      if (s_hi !== 14'b00000000000000) begin
        errors++; $display("FAIL invalid_hi code=%0d got=%b exp=%b", k, s_hi, 14'b0);
      end
      checks++;
      if (s_lo !== 14'b11111111111111) begin
        errors++; $display("FAIL invalid_lo code=%0d got=%b exp=%b", k, s_lo, 14'h3fff);
      end
    end
  endtask

  task automatic test_latency_hold();
    @(negedge clk);
    set_code(5'd7);
    @(posedge clk); #1;
    checks++;
    if (s_hi !== 14'b01101111000000) begin
      errors++; $display("FAIL hold_H got=%b exp=%b", s_hi, 14'b01101111000000);
    end
    @(negedge clk);
    set_code(5'b01110);
    #1;
    checks++;
    if (s_hi !== 14'b01101111000000) begin
      errors++; $display("FAIL hold_before_edge got=%b exp=%b", s_hi, 14'b01101111000000);
    end
    @(posedge clk); #1;
    checks++;
    if (s_hi !== 14'b11111100000000) begin
      errors++; $display("FAIL hold_O got=%b exp=%b", s_hi, 14'b11111100000000);
    end
    #2;
    set_code(5'd23);
    #1;
    checks++;
    if (s_hi !== 14'b11111100000000) begin
      errors++; $display("FAIL midcycle_hold got=%b exp=%b", s_hi, 14'b11111100000000);
    end
    @(posedge clk); #1;
    checks++;
    if (s_hi !== 14'b00000000101101) begin
      errors++; $display("FAIL midcycle_X got=%b exp=%b", s_hi, 14'b00000000101101);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    set_code(5'b10011);
    @(posedge clk); #1;
    checks++;
    if (s_hi !== 14'b10000000010010) begin
      errors++; $display("FAIL async_T got=%b exp=%b", s_hi, 14'b10000000010010);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_hi !== 14'b00000000000000) begin
      errors++; $display("FAIL async_blank_hi got=%b exp=%b", s_hi, 14'b0);
    end
    checks++;
    if (s_lo !== 14'b11111111111111) begin
      errors++; $display("FAIL async_blank_lo got=%b exp=%b", s_lo, 14'h3fff);
    end
    @(posedge clk); #1;
    checks++;
    if (s_hi !== 14'b00000000000000) begin
      errors++; $display("FAIL reset_held got=%b exp=%b", s_hi, 14'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_hi !== 14'b10000000010010) begin
      errors++; $display("FAIL async_restore_T got=%b exp=%b", s_hi, 14'b10000000010010);
    end
    checks++;
    if (s_lo !== 14'b01111111101101) begin
      errors++; $display("FAIL async_restore_T_lo got=%b exp=%b", s_lo, 14'b01111111101101);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  seq [0:3];
    logic [0:13] exp [0:3];
    seq[0] = 5'd25; exp[0] = 14'b10010000001100;
    seq[1] = 5'd31; exp[1] = 14'b00000000000000;
    seq[2] = 5'd1;  exp[2] = 14'b11110001010010;
    seq[3] = 5'd24; exp[3] = 14'b00000000101010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_code(seq[k]);
      @(posedge clk); #1;
      checks++;
      if (s_hi !== exp[k]) begin
        errors++; $display("FAIL b2b step=%0d got=%b exp=%b", k, s_hi, exp[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_invalid();
    test_latency_hold();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
